// File: rtl/ahb_master_req_ctrl_if.sv
// Command and AHB-side signal bundle for one bus master's request/transfer controller.
// The master modport is the controller's view; slave is the arbiter/slave/client side.
interface ahb_master_req_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic              cmd_lock;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              HBUSREQ;
  logic              HLOCK;
  logic              HGRANT;
  logic              HREADY;
  logic [1:0]        HRESP;
  logic [DATA_W-1:0] HRDATA;
  logic [1:0]        HTRANS;
  logic [ADDR_W-1:0] HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [DATA_W-1:0] HWDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_lock, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output HBUSREQ, HLOCK,
    input  HGRANT, HREADY, HRESP, HRDATA,
    output HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_lock, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  HBUSREQ, HLOCK,
    output HGRANT, HREADY, HRESP, HRDATA,
    input  HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA
  );
endinterface

// File: rtl/ahb_master_req_ctrl.sv
// Per-master AHB request/transfer controller: turns one valid/ready command into an
// arbitrated single-beat NONSEQ transfer, re-arbitrating on RETRY/SPLIT.
module ahb_master_req_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_RETRY = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_master_req_ctrl_if.master bus
);

  // state  | meaning
  // IDLE   | cmd_ready high, waiting for a command
  // REQ    | HBUSREQ high, waiting for HGRANT & HREADY
  // ADDR   | NONSEQ address phase, waiting for HREADY
  // DATA   | data phase, waiting for completion or RETRY/SPLIT
  // RESP   | one-cycle rsp_valid pulse
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  localparam int              CNT_W      = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(MAX_RETRY - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  retry_cnt;
  logic              hold_write;
  logic              hold_lock;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;

  assign bus.HSIZE  = 3'b010;
  assign bus.HBURST = 3'b000;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state         <= S_IDLE;
      retry_cnt     <= '0;
      hold_write    <= 1'b0;
      hold_lock     <= 1'b0;
      hold_addr     <= '0;
      hold_wdata    <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.HBUSREQ   <= 1'b0;
      bus.HLOCK     <= 1'b0;
      bus.HTRANS    <= TRANS_IDLE;
      bus.HADDR     <= '0;
      bus.HWRITE    <= 1'b0;
      bus.HWDATA    <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            hold_write    <= bus.cmd_write;
            hold_lock     <= bus.cmd_lock;
            hold_addr     <= bus.cmd_addr;
            hold_wdata    <= bus.cmd_wdata;
            retry_cnt     <= '0;
            bus.cmd_ready <= 1'b0;
            bus.HBUSREQ   <= 1'b1;
            bus.HLOCK     <= bus.cmd_lock;
            state         <= S_REQ;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end

        S_REQ: begin
          if (bus.HGRANT && bus.HREADY) begin
            bus.HTRANS <= TRANS_NONSEQ;
            bus.HADDR  <= hold_addr;
            bus.HWRITE <= hold_write;
            state      <= S_ADDR;
          end
        end

        S_ADDR: begin
          // Grant is no longer consulted: ownership was won on entry to ADDR.
          if (bus.HREADY) begin
            bus.HTRANS  <= TRANS_IDLE;
            bus.HBUSREQ <= 1'b0;
            if (hold_write) begin
              bus.HWDATA <= hold_wdata;
            end
            state <= S_DATA;
          end
        end

        S_DATA: begin
          // RETRY/SPLIT is acted on in its first (HREADY low) cycle and wins over HREADY.
          if (bus.HRESP[1]) begin
            retry_cnt <= retry_cnt + 1'b1;
            if (retry_cnt >= RETRY_LAST) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
              bus.HLOCK     <= 1'b0;
              state         <= S_RESP;
            end else begin
              bus.HBUSREQ <= 1'b1;
              bus.HLOCK   <= hold_lock;
              state       <= S_REQ;
            end
          end else if (bus.HREADY) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= bus.HRESP[0];
            bus.rsp_rdata <= (!bus.HRESP[0] && !hold_write) ? bus.HRDATA : '0;
            bus.HLOCK     <= 1'b0;
            state         <= S_RESP;
          end
        end

        S_RESP: begin
          bus.cmd_ready <= 1'b1;
          state         <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Bench for ahb_master_req_ctrl: protocol-aware slave/arbiter driver, a phase-level
// reference model compared every cycle, and per-command outcome/latency expectations.
`timescale 1ns/1ps
module tb_ahb_master_req_ctrl;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_RETRY = 4;
  localparam logic [1:0] R_OKAY  = 2'b00;
  localparam logic [1:0] R_ERROR = 2'b01;
  localparam logic [1:0] R_RETRY = 2'b10;
  localparam logic [1:0] R_SPLIT = 2'b11;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;

  ahb_master_req_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ahb_master_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RETRY(MAX_RETRY)) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus.master)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model: bus phase per the protocol rules ----------------
  typedef enum int {P_IDLE, P_REQ, P_ADDR, P_DATA, P_RESP} phase_t;
  phase_t      m_phase;
  bit          e_ready, e_valid, e_err, e_busreq, e_lock;
  logic [1:0]  e_trans;
  logic [31:0] e_rdata;
  bit          m_write, m_lock;
  logic [31:0] m_addr, m_wdata;
  int          m_retries;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_phase = P_IDLE; e_ready = 0; e_valid = 0; e_err = 0; e_busreq = 0; e_lock = 0;
      e_trans = 2'b00; e_rdata = '0; m_retries = 0;
    end else begin
      e_valid = 0;
      case (m_phase)
        P_IDLE: if (bus.cmd_valid && e_ready) begin
          m_write = bus.cmd_write; m_lock = bus.cmd_lock;
          m_addr = bus.cmd_addr; m_wdata = bus.cmd_wdata; m_retries = 0;
          e_ready = 0; e_busreq = 1; e_lock = m_lock; m_phase = P_REQ;
        end else e_ready = 1;
        P_REQ: if (bus.HGRANT && bus.HREADY) begin e_trans = 2'b10; m_phase = P_ADDR; end
        P_ADDR: if (bus.HREADY) begin e_trans = 2'b00; e_busreq = 0; m_phase = P_DATA; end
        P_DATA: begin
          if (bus.HRESP == R_RETRY || bus.HRESP == R_SPLIT) begin
            m_retries++;
            if (m_retries == MAX_RETRY) begin
              e_valid = 1; e_err = 1; e_lock = 0; m_phase = P_RESP;
            end else begin
              e_busreq = 1; e_lock = m_lock; m_phase = P_REQ;
            end
          end else if (bus.HREADY) begin
            e_valid = 1; e_err = (bus.HRESP == R_ERROR); e_lock = 0; m_phase = P_RESP;
            e_rdata = m_write ? 32'h0 : bus.HRDATA;
          end
        end
        P_RESP: begin e_ready = 1; m_phase = P_IDLE; end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare + activity counters ----------------
  logic [1:0]  prev_trans;
  bit          prev_busreq;
  int          nonseq_cnt, nonseq_cyc, busreq_cyc, busreq_rise, lock_cyc;
  logic [31:0] last_haddr, last_hwdata;

  always @(negedge HCLK) begin
    if (HRESETn) begin
      chk("cmd_ready", bus.cmd_ready, e_ready);
      chk("rsp_valid", bus.rsp_valid, e_valid);
      if (e_valid) begin
        chk("rsp_err", bus.rsp_err, e_err);
        if (!e_err) chk("rsp_rdata", bus.rsp_rdata, e_rdata);
      end
      chk("HBUSREQ", bus.HBUSREQ, e_busreq);
      chk("HLOCK", bus.HLOCK, e_lock);
      chk("HTRANS", bus.HTRANS, e_trans);
      if (e_trans == 2'b10) begin
        chk("HADDR", bus.HADDR, m_addr);
        chk("HWRITE", bus.HWRITE, m_write);
      end
      if (m_phase == P_DATA && m_write) chk("HWDATA", bus.HWDATA, m_wdata);
      chk("HSIZE", bus.HSIZE, 3'b010);
      chk("HBURST", bus.HBURST, 3'b000);
      if (bus.HTRANS == 2'b10) begin
        nonseq_cyc++; last_haddr = bus.HADDR;
        if (prev_trans != 2'b10) nonseq_cnt++;
      end
      if (m_phase == P_DATA) last_hwdata = bus.HWDATA;
      if (bus.HBUSREQ) busreq_cyc++;
      if (bus.HBUSREQ && !prev_busreq) busreq_rise++;
      if (bus.HLOCK) lock_cyc++;
      prev_trans  = bus.HTRANS;
      prev_busreq = bus.HBUSREQ;
    end else begin
      prev_trans  = 2'b00;
      prev_busreq = 0;
    end
  end

  // ---------------- arbiter/slave driver following a per-command response plan ----------------
  int          cfg_gdelay, cfg_dwait;
  bit          cfg_rand_ready, cfg_fixed_rdata;
  logic [31:0] cfg_rdata;
  logic [1:0]  plan[$];
  int          attempt, req_cnt, gdel, dwait;
  bit          err_stage, retry_tail;
  logic [1:0]  tail_resp, drv_r;
  phase_t      drv_prev = P_IDLE;

  always begin
    @(negedge HCLK);
    #1;
    if (m_phase != drv_prev) begin
      if (m_phase == P_REQ) begin
        req_cnt = 0;
        gdel = (cfg_gdelay < 0) ? int'($urandom_range(0, 3)) : cfg_gdelay;
      end
      if (m_phase == P_DATA) begin
        attempt++;
        dwait = (cfg_dwait < 0) ? int'($urandom_range(0, 2)) : cfg_dwait;
        err_stage = 0;
      end
      drv_prev = m_phase;
    end
    bus.HRDATA = cfg_fixed_rdata ? cfg_rdata : $urandom;
    bus.HRESP  = R_OKAY;
    bus.HREADY = cfg_rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.HGRANT = 1'($urandom_range(0, 1));
    case (m_phase)
      P_REQ: begin bus.HGRANT = (req_cnt >= gdel); req_cnt++; end
      P_DATA: begin
        if (dwait > 0) begin bus.HREADY = 0; dwait--; end
        else begin
          drv_r = (attempt <= plan.size()) ? plan[attempt-1] : R_OKAY;
          if (drv_r == R_OKAY) bus.HREADY = 1;
          else if (drv_r == R_ERROR) begin
            bus.HRESP = R_ERROR; bus.HREADY = err_stage; err_stage = 1;
          end else begin
            bus.HRESP = drv_r; bus.HREADY = 0; retry_tail = 1; tail_resp = drv_r;
          end
        end
      end
      default: ;
    endcase
    // Second cycle of a RETRY/SPLIT lands after the master has left DATA.
    if (retry_tail && m_phase != P_DATA) begin
      bus.HREADY = 1; bus.HRESP = tail_resp; retry_tail = 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic reset_checks(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_rsp_err"},   bus.rsp_err, 0);
    chk({tag, "_HBUSREQ"},   bus.HBUSREQ, 0);
    chk({tag, "_HLOCK"},     bus.HLOCK, 0);
    chk({tag, "_HTRANS"},    bus.HTRANS, 2'b00);
    chk({tag, "_HADDR"},     bus.HADDR, 0);
    chk({tag, "_HWRITE"},    bus.HWRITE, 0);
    chk({tag, "_HWDATA"},    bus.HWDATA, 0);
  endtask

  task automatic run_cmd(input bit wr, input bit lk, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output bit err, output logic [31:0] rd, output bit ok);
    int n;
    @(negedge HCLK);
    #1;
    attempt = 0;
    bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_lock = lk; bus.cmd_addr = a; bus.cmd_wdata = d;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin @(negedge HCLK); #1; n++; end
    ok = 0; err = 0; rd = '0; lat = 0;
    if (n >= 50) begin
      chk("accept_timeout", bus.cmd_ready, 1);
      bus.cmd_valid = 0;
      return;
    end
    nonseq_cnt = 0; nonseq_cyc = 0; busreq_cyc = 0; busreq_rise = 0; lock_cyc = 0;
    do begin
      @(negedge HCLK);
      #1;
      lat++;
      if (!bus.rsp_valid) begin
        // Command inputs must be ignored while a transfer is in flight.
        bus.cmd_valid = 1'($urandom_range(0, 1)); bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_lock = 1'($urandom_range(0, 1)); bus.cmd_addr = $urandom; bus.cmd_wdata = $urandom;
      end
    end while (!bus.rsp_valid && lat < 300);
    bus.cmd_valid = 0;
    ok = bus.rsp_valid;
    if (!ok) chk("rsp_timeout", bus.rsp_valid, 1);
    err = bus.rsp_err;
    rd  = bus.rsp_rdata;
  endtask

  function automatic void plan_outcome(output int phases, output bit err);
    logic [1:0] r;
    phases = 0; err = 0;
    for (int k = 0; k < MAX_RETRY; k++) begin
      r = (k < plan.size()) ? plan[k] : R_OKAY;
      if (r == R_RETRY || r == R_SPLIT) begin
        if (k == MAX_RETRY - 1) begin phases = MAX_RETRY; err = 1; return; end
      end else begin
        phases = k + 1; err = (r == R_ERROR); return;
      end
    end
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lat, ph, n, rv, u;
    bit err, ok, perr;
    logic [31:0] rd;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_lock = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.HGRANT = 0; bus.HREADY = 1; bus.HRESP = R_OKAY; bus.HRDATA = '0;
    cfg_gdelay = 0; cfg_dwait = 0; cfg_rand_ready = 0; cfg_fixed_rdata = 0; cfg_rdata = '0;

    repeat (3) @(negedge HCLK);
    reset_checks("rst");
    #1 HRESETn = 1;
    @(negedge HCLK);
    chk("ready_after_release", bus.cmd_ready, 1);

    // Plain read, grant immediate, no waits.
    plan = '{R_OKAY}; cfg_fixed_rdata = 1; cfg_rdata = 32'hDEADBEEF;
    run_cmd(0, 0, 32'h100, 32'h0, lat, err, rd, ok);
    chk("t1_latency", lat, 4);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_err", err, 0);
    chk("t1_nonseq_cycles", nonseq_cyc, 1);
    chk("t1_haddr", last_haddr, 32'h100);
    cfg_fixed_rdata = 0;

    // Write with grant withheld for the first 4 REQ cycles.
    cfg_gdelay = 4;
    run_cmd(1, 0, 32'h200, 32'hA5A5A5A5, lat, err, rd, ok);
    chk("t2_busreq_cycles", busreq_cyc, 6);
    chk("t2_latency", lat, 8);
    chk("t2_hwdata", last_hwdata, 32'hA5A5A5A5);
    chk("t2_err", err, 0);
    cfg_gdelay = 0;

    // Read with three data-phase wait states.
    cfg_dwait = 3;
    run_cmd(0, 0, 32'h304, 32'h0, lat, err, rd, ok);
    chk("t3_latency", lat, 7);
    chk("t3_nonseq", nonseq_cnt, 1);
    chk("t3_err", err, 0);
    cfg_dwait = 0;

    // RETRY twice then OKAY.
    plan = '{R_RETRY, R_RETRY, R_OKAY};
    run_cmd(0, 0, 32'h400, 32'h0, lat, err, rd, ok);
    chk("t4_nonseq", nonseq_cnt, 3);
    chk("t4_busreq_rises", busreq_rise, 3);
    chk("t4_latency", lat, 10);
    chk("t4_err", err, 0);

    // SPLIT forever: abort after MAX_RETRY address phases.
    plan = '{R_SPLIT, R_SPLIT, R_SPLIT, R_SPLIT, R_SPLIT, R_SPLIT};
    run_cmd(1, 0, 32'h404, 32'h1234, lat, err, rd, ok);
    chk("t4b_nonseq", nonseq_cnt, MAX_RETRY);
    chk("t4b_err", err, 1);
    chk("t4b_latency", lat, 3 * MAX_RETRY + 1);

    // Locked write answered with a two-cycle ERROR.
    plan = '{R_ERROR};
    run_cmd(1, 1, 32'h500, 32'h0F0F0F0F, lat, err, rd, ok);
    chk("t5_err", err, 1);
    chk("t5_lock_cycles", lock_cyc, 4);
    chk("t5_lock_in_resp", bus.HLOCK, 0);
    chk("t5_latency", lat, 5);

    // Reset asserted during the address phase.
    plan = '{R_OKAY};
    @(negedge HCLK);
    #1;
    bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_lock = 1; bus.cmd_addr = 32'h600; bus.cmd_wdata = 32'h77;
    n = 0;
    while (bus.HTRANS != 2'b10 && n < 20) begin
      @(negedge HCLK);
      #1;
      n++;
      if (!bus.cmd_ready) bus.cmd_valid = 0;
    end
    bus.cmd_valid = 0;
    chk("pre_rst_htrans", bus.HTRANS, 2'b10);
    #2 HRESETn = 0;
    #1 reset_checks("mid_rst");
    @(negedge HCLK);
    #1 HRESETn = 1;
    @(negedge HCLK);
    chk("mid_rst_ready_after_release", bus.cmd_ready, 1);
    rv = 0;
    repeat (8) begin @(negedge HCLK); if (bus.rsp_valid) rv++; end
    chk("mid_rst_no_rsp", rv, 0);

    // Randomised commands, responses, grants and wait states.
    cfg_gdelay = -1; cfg_dwait = -1; cfg_rand_ready = 1;
    for (int i = 0; i < 120; i++) begin
      plan.delete();
      for (int k = 0; k < 5; k++) begin
        u = int'($urandom_range(0, 99));
        plan.push_back(u < 50 ? R_OKAY : u < 65 ? R_ERROR : u < 85 ? R_RETRY : R_SPLIT);
      end
      plan_outcome(ph, perr);
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, lat, err, rd, ok);
      if (ok) begin
        chk("rand_err", err, perr);
        chk("rand_addr_phases", nonseq_cnt, ph);
      end
      repeat ($urandom_range(0, 2)) @(negedge HCLK);
    end

    repeat (3) @(negedge HCLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
